// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-to-data-memory request/response bundle
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-lane data RAM answering core loads/stores after wait states
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        perform;
    logic        accept;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_f3;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          range_err, align_err, f3_err, err;
    logic [3:0]    be;
    logic [31:0]   wshift, rword, rshift, ldata;

    assign bus.req_ready = rst && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    // The accept edge always lands in WAIT, so the RAM access sits WAIT_STATES+1 edges after accept.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        perform  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = WAIT;
                    cnt_nx   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    perform  = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign off       = lat_addr - ADDR_BASE;
    assign lane      = off[1:0];
    assign widx      = off[AW+1:2];
    assign range_err = (off[31:2] >= 30'(DEPTH_WORDS));
    assign f3_err    = lat_we ? (lat_f3 > 3'd2) : ((lat_f3 == 3'd3) || (lat_f3 >= 3'd6));
    assign align_err = (lat_f3[1:0] == 2'd1) ? lane[0] :
                       (lat_f3[1:0] == 2'd2) ? (lane != 2'd0) : 1'b0;
    assign err       = range_err || f3_err || align_err;

    always_comb begin
        case (lat_f3[1:0])
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
    end

    assign wshift = lat_wdata << {lane, 3'b000};
    assign rword  = mem[widx];
    assign rshift = rword >> {lane, 3'b000};

    always_comb begin
        case (lat_f3)
            3'd0:    ldata = {{24{rshift[7]}}, rshift[7:0]};
            3'd1:    ldata = {{16{rshift[15]}}, rshift[15:0]};
            3'd4:    ldata = {24'd0, rshift[7:0]};
            3'd5:    ldata = {16'd0, rshift[15:0]};
            default: ldata = rword;
        endcase
    end

    // RAM has no reset; a reset edge suppresses a store that would otherwise land on it.
    always_ff @(posedge clk) begin
        if (rst && perform && lat_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            lat_we        <= 1'b0;
            lat_addr      <= 32'd0;
            lat_wdata     <= 32'd0;
            lat_f3        <= 3'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_f3    <= bus.req_funct3;
            end
            if (perform) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= err;
                bus.rsp_rdata <= (err || lat_we) ? 32'd0 : ldata;
            end else if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized load/store bench against a byte-addressed reference model
module tb_dmem_responder;
    localparam int          D1 = 256;
    localparam int          D3 = 64;
    localparam logic [31:0] B1 = 32'h0000_0000;
    localparam logic [31:0] B3 = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    dmem_responder_if if1 ();
    dmem_responder_if if3 ();

    dmem_responder #(.DEPTH_WORDS(D1), .WAIT_STATES(1), .ADDR_BASE(B1))
        u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
    dmem_responder #(.DEPTH_WORDS(D3), .WAIT_STATES(3), .ADDR_BASE(B3))
        u_dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mbytes [2][D1*4];
    logic [32:0] q1 [$];
    logic [32:0] q3 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Memory seen as a flat byte array; load/store semantics straight from the ISA rules.
    task automatic model(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         output bit err, output logic [31:0] rdata);
        int unsigned    depth;
        logic [31:0]    off;
        int             nbytes;
        bit             legal;
        longint unsigned v;
        depth  = (d == 0) ? D1 : D3;
        off    = addr - ((d == 0) ? B1 : B3);
        nbytes = 1 << f3[1:0];
        legal  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err    = 1'b0;
        rdata  = 32'd0;
        if (!legal || (off / 4) >= depth || (off % nbytes) != 0) begin
            err = 1'b1;
        end else if (we) begin
            for (int k = 0; k < nbytes; k++) mbytes[d][off + k] = wdata[8*k +: 8];
        end else begin
            v = 0;
            for (int k = 0; k < nbytes; k++) v = v | (longint'(mbytes[d][off + k]) << (8*k));
            if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | (~64'd0 << (8*nbytes));
            rdata = v[31:0];
        end
    endtask

    function automatic logic req_ready_of(input int d);
        return (d == 0) ? if1.req_ready : if3.req_ready;
    endfunction
    function automatic logic rsp_valid_of(input int d);
        return (d == 0) ? if1.rsp_valid : if3.rsp_valid;
    endfunction
    function automatic logic [32:0] rsp_of(input int d);
        return (d == 0) ? {if1.rsp_err, if1.rsp_rdata} : {if3.rsp_err, if3.rsp_rdata};
    endfunction

    task automatic set_req(input int d, input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3);
        if (d == 0) begin
            if1.req_valid = v; if1.req_we = we; if1.req_addr = addr;
            if1.req_wdata = wdata; if1.req_funct3 = f3;
        end else begin
            if3.req_valid = v; if3.req_we = we; if3.req_addr = addr;
            if3.req_wdata = wdata; if3.req_funct3 = f3;
        end
    endtask

    task automatic set_rsp_ready(input int d, input logic r);
        if (d == 0) if1.rsp_ready = r; else if3.rsp_ready = r;
    endtask

    task automatic check_rsp(input string nm, input logic [32:0] act, input bit have,
                             input logic [32:0] exp);
        vectors++;
        if (!have) begin
            miscompares++;
            $display("FAIL %s: unexpected response err=%0b rdata=%h, none required", nm, act[32], act[31:0]);
        end else if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got err=%0b rdata=%h, required err=%0b rdata=%h",
                     nm, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Every cycle a response is presented it must match the oldest outstanding model result.
    always @(negedge clk) begin
        if (if1.rsp_valid) check_rsp("rsp1", rsp_of(0), q1.size() != 0, (q1.size() != 0) ? q1[0] : 33'd0);
        if (if3.rsp_valid) check_rsp("rsp3", rsp_of(1), q3.size() != 0, (q3.size() != 0) ? q3[0] : 33'd0);
    end

    always @(posedge clk) begin
        if (if1.rsp_valid && if1.rsp_ready && q1.size() != 0) void'(q1.pop_front());
        if (if3.rsp_valid && if3.rsp_ready && q3.size() != 0) void'(q3.pop_front());
    end

    task automatic txn(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, input int hold, output logic err, output logic [31:0] rdata);
        bit          e_err;
        logic [31:0] e_rd;
        int          t;
        int          lat;
        err   = 1'b1;
        rdata = 32'hxxxx_xxxx;
        @(negedge clk);
        set_req(d, 1'b1, we, addr, wdata, f3);
        set_rsp_ready(d, 1'b0);
        t = 0;
        while (!req_ready_of(d) && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) begin
            chk("accept_timeout", 32'(t), 32'd0);
            set_req(d, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
            return;
        end
        @(posedge clk);
        model(d, we, addr, wdata, f3, e_err, e_rd);
        if (d == 0) q1.push_back({e_err, e_rd}); else q3.push_back({e_err, e_rd});
        @(negedge clk);
        set_req(d, 1'b0, $urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 7)));
        lat = 0;
        while (!rsp_valid_of(d) && lat < 40) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), (d == 0) ? 32'd2 : 32'd4);
        {err, rdata} = rsp_of(d);
        for (int h = 0; h < hold; h++) begin
            set_req(d, 1'b1, 1'b1, addr ^ 32'h4, $urandom, 3'd2);
            chk("busy_req_ready", 32'(req_ready_of(d)), 32'd0);
            chk("held_rsp_valid", 32'(rsp_valid_of(d)), 32'd1);
            @(negedge clk);
        end
        set_req(d, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_rsp_ready(d, 1'b1);
        @(negedge clk);
        chk("rsp_valid_drop", 32'(rsp_valid_of(d)), 32'd0);
        chk("idle_req_ready", 32'(req_ready_of(d)), 32'd1);
        set_rsp_ready(d, 1'b0);
    endtask

    task automatic dir(input string nm, input int d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3, input int hold,
                       input logic exp_err, input logic [31:0] exp_rd);
        logic        e;
        logic [31:0] r;
        txn(d, we, addr, wdata, f3, hold, e, r);
        chk({nm, "_err"}, 32'(e), 32'(exp_err));
        chk({nm, "_rdata"}, r, exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        logic        e;
        logic [31:0] r;
        int          d;
        logic [31:0] addr;
        int unsigned sel;

        rst1 = 1'b0;
        rst3 = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_rsp_ready(0, 1'b0);
        set_rsp_ready(1, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_rsp_valid", 32'(rsp_valid_of(i)), 32'd0);
            chk("reset_req_ready", 32'(req_ready_of(i)), 32'd0);
            chk("reset_rsp", 32'(rsp_of(i)), 32'd0);
        end
        rst1 = 1'b1;
        rst3 = 1'b1;
        @(negedge clk);
        chk("post_reset_ready1", 32'(req_ready_of(0)), 32'd1);
        chk("post_reset_ready3", 32'(req_ready_of(1)), 32'd1);

        for (int w = 0; w < 16; w++) begin
            txn(0, 1'b1, B1 + 32'(4*w), $urandom, 3'd2, 0, e, r);
            txn(1, 1'b1, B3 + 32'(4*w), $urandom, 3'd2, 0, e, r);
        end

        dir("sw",        0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 1'b0, 32'h0000_0000);
        dir("lw",        0, 1'b0, 32'h10, 32'h0,        3'd2, 0, 1'b0, 32'hDEADBEEF);
        dir("lb",        0, 1'b0, 32'h13, 32'h0,        3'd0, 0, 1'b0, 32'hFFFFFFDE);
        dir("lbu",       0, 1'b0, 32'h13, 32'h0,        3'd4, 0, 1'b0, 32'h000000DE);
        dir("lh",        0, 1'b0, 32'h10, 32'h0,        3'd1, 0, 1'b0, 32'hFFFFBEEF);
        dir("lhu",       0, 1'b0, 32'h12, 32'h0,        3'd5, 0, 1'b0, 32'h0000DEAD);
        dir("sb",        0, 1'b1, 32'h11, 32'h00000055, 3'd0, 0, 1'b0, 32'h0);
        dir("sh",        0, 1'b1, 32'h12, 32'h00001234, 3'd1, 0, 1'b0, 32'h0);
        dir("lw_merge",  0, 1'b0, 32'h10, 32'h0,        3'd2, 0, 1'b0, 32'h123455EF);
        dir("lw_mis",    0, 1'b0, 32'h11, 32'h0,        3'd2, 0, 1'b1, 32'h0);
        dir("sh_mis",    0, 1'b1, 32'h13, 32'hFFFFFFFF, 3'd1, 0, 1'b1, 32'h0);
        dir("lw_kept",   0, 1'b0, 32'h10, 32'h0,        3'd2, 5, 1'b0, 32'h123455EF);
        dir("lw_oor",    0, 1'b0, 32'(4*D1), 32'h0,     3'd2, 0, 1'b1, 32'h0);
        dir("ld_f3",     0, 1'b0, 32'h10, 32'h0,        3'd3, 0, 1'b1, 32'h0);
        dir("st_f3",     0, 1'b1, 32'h10, 32'h0,        3'd4, 0, 1'b1, 32'h0);
        dir("lw_below3", 1, 1'b0, B3 - 32'd4, 32'h0,    3'd2, 0, 1'b1, 32'h0);

        // Store aborted by reset during its second wait cycle must leave the word untouched.
        dir("sw3",       1, 1'b1, B3 + 32'h20, 32'h11223344, 3'd2, 0, 1'b0, 32'h0);
        @(negedge clk);
        chk("abort_ready", 32'(req_ready_of(1)), 32'd1);
        set_req(1, 1'b1, 1'b1, B3 + 32'h20, 32'hA5A5A5A5, 3'd2);
        @(posedge clk);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        rst3 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_rsp_valid", 32'(rsp_valid_of(1)), 32'd0);
            chk("abort_req_ready", 32'(req_ready_of(1)), 32'd0);
        end
        rst3 = 1'b1;
        dir("lw3_after", 1, 1'b0, B3 + 32'h20, 32'h0, 3'd2, 0, 1'b0, 32'h11223344);

        for (int i = 0; i < 120; i++) begin
            d   = (i % 3 == 2) ? 1 : 0;
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = ((d == 0) ? B1 : B3) + 32'(4 * ((d == 0) ? D1 : D3)) + 32'($urandom_range(0, 15));
            else if (sel == 1) addr = ((d == 0) ? B1 : B3) - 32'($urandom_range(1, 8));
            else               addr = ((d == 0) ? B1 : B3) + 32'($urandom_range(0, 63));
            txn(d, 1'($urandom_range(0, 1)), addr, $urandom, 3'($urandom_range(0, 7)),
                $urandom_range(0, 2), e, r);
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
